// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM state type shared by the sequential ALU
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_BGT  = 4'd9;
    localparam logic [3:0] OP_BGE  = 4'd10;
    localparam logic [3:0] OP_BLE  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - one-bit-per-cycle shift-add multiplier / restoring divider
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    // hi/lo/opnd are shared: MULT uses {partial high, multiplier->product low, A},
    // DIV uses {remainder, dividend->quotient, B}.
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             mode_div;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] nhi, nlo;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        nhi     = '0;
        nlo     = '0;
        if (mode_div) begin
            // A zero divisor always "fits", giving all-ones quotient and remainder = A.
            if (shifted >= {1'b0, opnd}) begin
                nhi = diff[WIDTH-1:0];
                nlo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                nhi = shifted[WIDTH-1:0];
                nlo = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nhi = sum[WIDTH:1];
            nlo = {sum[0], lo[WIDTH-1:1]};
        end
    end

    // Final-iteration values are exposed combinationally so the owner can
    // register them on the same edge that ends the operation.
    assign done   = busy && (cnt == CW'(WIDTH - 1));
    assign res_lo = nlo;
    assign res_hi = nhi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            mode_div <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            hi       <= '0;
            lo       <= is_div ? a : b;
            opnd     <= is_div ? b : a;
            cnt      <= '0;
            busy     <= 1'b1;
            mode_div <= is_div;
            div_zero <= is_div && (b == '0);
        end else if (busy) begin
            hi  <= nhi;
            lo  <= nlo;
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle ops and iterative MULT/DIV
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [3:0]       ALU_Control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
);
    state_t           state;
    logic [WIDTH-1:0] sc_result;
    logic             sc_zero;
    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             md_dz;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && (ALU_Control == OP_MULT || ALU_Control == OP_DIV);

    always_comb begin
        sc_result = '0;
        sc_zero   = 1'b0;
        case (ALU_Control)
            OP_ADD: sc_result = in_A + in_B;
            OP_SUB: begin
                sc_result = in_A - in_B;
                sc_zero   = (in_A == in_B);
            end
            OP_AND: sc_result = in_A & in_B;
            OP_OR:  sc_result = in_A | in_B;
            OP_NOR: sc_result = ~(in_A | in_B);
            OP_XOR: sc_result = in_A ^ in_B;
            OP_BNE: sc_zero   = (in_A != in_B);
            OP_BGT: sc_zero   = (in_A > in_B);
            OP_BGE: sc_zero   = (in_A >= in_B);
            OP_BLE: sc_zero   = (in_A <= in_B);
            default: ;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (md_start),
        .is_div   (ALU_Control == OP_DIV),
        .a        (in_A),
        .b        (in_B),
        .done     (md_done),
        .res_lo   (md_lo),
        .res_hi   (md_hi),
        .div_zero (md_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ALU_Result  <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ALU_Result  <= sc_result;
                        result_hi   <= '0;
                        zero        <= sc_zero;
                        div_by_zero <= 1'b0;
                        if (ALU_Control == OP_MULT) begin
                            state <= ST_MUL;
                        end else if (ALU_Control == OP_DIV) begin
                            state <= ST_DIV;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_done) begin
                        ALU_Result  <= md_lo;
                        result_hi   <= md_hi;
                        zero        <= 1'b0;
                        div_by_zero <= md_dz;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts a request this cycle.
REQ-006 in_A  input  WIDTH  operand A, unsigned.
REQ-007 in_B  input  WIDTH  operand B, unsigned.
REQ-008 ALU_Control  input  4  opcode: 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 AND, 5 OR, 6 NOR, 7 XOR, 8 BNE, 9 BGT, 10 BGE, 11 BLE, 12-15 reserved.
REQ-009 out_valid  output  1  result registers hold a completed operation.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 ALU_Result  output  WIDTH  primary result (sum, difference, product low word, quotient, logic result).
REQ-012 result_hi  output  WIDTH  product high word (MULT), remainder (DIV), else 0.
REQ-013 zero  output  1  condition flag per REQ-019.
REQ-014 div_by_zero  output  1  DIV issued with in_B == 0.

Function
REQ-015 Accept = in_valid && in_ready; operands and opcode captured at accept; later input changes are ignored.
REQ-016 in_ready = 1 only in state IDLE.
REQ-017 FSM states IDLE, MUL, DIV, DONE; IDLE->DONE on accept of ops 0,1,4-11,12-15; IDLE->MUL on accept of op 2; IDLE->DIV on accept of op 3; MUL/DIV->DONE after WIDTH iteration cycles; DONE->IDLE when out_ready; DONE holds otherwise.
REQ-018 out_valid = 1 exactly in DONE; all outputs stable while out_valid && !out_ready.
REQ-019 zero: SUB -> (A==B); BNE -> (A!=B); BGT -> (A>B); BGE -> (A>=B); BLE -> (A<=B); all other ops -> 0.
REQ-020 ADD/SUB results modulo 2^WIDTH; logic ops bitwise; branch ops ALU_Result = 0, result_hi = 0.
REQ-021 Latency accept-to-out_valid: 1 cycle for single-cycle ops; WIDTH+1 cycles for MULT and DIV.
REQ-022 MULT: shift-add, one bit per cycle, full 2*WIDTH-bit unsigned product split {result_hi, ALU_Result}.
REQ-023 DIV: restoring, one quotient bit per cycle, ALU_Result = A/B, result_hi = A%B.
REQ-024 DIV with B==0: still WIDTH+1 cycles; ALU_Result = all ones, result_hi = A, div_by_zero = 1; div_by_zero = 0 for every other completion.
REQ-025 Reserved opcodes complete in 1 cycle with ALU_Result = 0, result_hi = 0, zero = 0.
REQ-026 Back-to-back: new accept possible the cycle after DONE->IDLE; no accept while busy, in_valid held is accepted on return to IDLE.
REQ-027 Iteration counter width ceil(log2(WIDTH+1)); counter and partial registers cleared at each accept.

Reset
REQ-028 rst_n low asynchronously forces state IDLE, out_valid 0, ALU_Result 0, result_hi 0, zero 0, div_by_zero 0, counter and partial registers 0.
REQ-029 Reset mid-MUL/DIV or in DONE abandons the operation; no result is presented after release.
REQ-030 First accept possible on the first rising edge with rst_n high.

Structure
REQ-031 Shared package alu_pkg holds opcode localparams (OP_ADD..OP_BLE) and the FSM state enum.
REQ-032 One sub-module alu_muldiv_iter: iterative multiply/divide datapath with start, op select, done pulse; alu_seq owns handshake, FSM and single-cycle ops.

Verification
REQ-033 WIDTH=32, ADD A=0xFFFFFFFF B=1 -> out_valid 1 cycle after accept, ALU_Result 0, zero 0.
REQ-034 SUB A=B=0x1234 -> ALU_Result 0, zero 1; BGT A=5 B=7 -> zero 0, ALU_Result 0.
REQ-035 MULT A=0xFFFFFFFF B=0xFFFFFFFF -> out_valid after 33 cycles, result_hi 0xFFFFFFFE, ALU_Result 0x00000001.
REQ-036 DIV A=100 B=7 -> ALU_Result 14, result_hi 2; DIV A=9 B=0 -> ALU_Result 0xFFFFFFFF, result_hi 9, div_by_zero 1.
REQ-037 out_ready held low 5 cycles after MULT completion -> outputs stable, in_ready 0; in_valid asserted meanwhile accepted only after DONE->IDLE.
REQ-038 rst_n pulsed low during cycle 10 of DIV -> out_valid stays 0, outputs 0, next ADD 2+3 returns 5.
